stream_merge: RTL and testbench

- N-to-1 valid/ready stream merger; each input lane has its own small FIFO, and lanes are served by a round-robin arbiter into a registered output stage that carries a channel-id tag.
- Both stream ports are modports of the shared parametrised interface stream_if; the block is instantiated between a multi-lane producer and a single-lane consumer.
- Parametrised successor of the fixed-width interface/modport plumbing: generalised in lane count, width and buffering depth, and it adds real handshakes.

---
 rtl/stream_pkg.sv | 9 +
 rtl/stream_if.sv | 13 +
 rtl/stream_fifo.sv | 56 +++++
 rtl/stream_merge.sv | 151 +++++++++++++++
 tb/tb_stream_merge.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared helpers for the stream merge slice
package stream_pkg;

    // Id width for a lane count; a single lane still gets a 1-bit id.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_if.sv
// rtl/stream_if.sv - LANES-wide valid/ready/last/data stream bundle with src and snk views
interface stream_if #(
    parameter int LANES = 1,
    parameter int WIDTH = 8
);
    logic [LANES-1:0]            valid;
    logic [LANES-1:0]            ready;
    logic [LANES-1:0]            last;
    logic [LANES-1:0][WIDTH-1:0] data;

    modport src (output valid, output last, output data, input ready);
    modport snk (input valid, input last, input data, output ready);
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - single-lane DEPTH-entry circular FIFO
// clk, rst (sync, active high); push/push_data write side; pop/pop_data read side
// (pop_data shows the head); full/empty come straight from the pointer flops.
module stream_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // One extra pointer bit tells a full buffer from an empty one.
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty    = (wr_q == rd_q);
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        // A full FIFO refuses the push even when a pop frees a slot this cycle.
        if (push && !full) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/stream_merge.sv
// rtl/stream_merge.sv - CHANNELS-to-1 round-robin stream merger, optional STREAM_MERGE_PACKET_LOCK_EN
// clk, rst (sync, active high); in: stream_if.snk, CHANNELS lanes, ready driven here;
// out: stream_if.src, one registered lane; out_id: source lane of the out beat;
// busy: any lane FIFO holds data or out.valid is high.
// With STREAM_MERGE_PACKET_LOCK_EN defined, a lane keeps the grant from its first
// last=0 beat until its last=1 beat has been loaded.
module stream_merge
    import stream_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 2,
    localparam int IDW      = idw(CHANNELS)
) (
    input  logic           clk,
    input  logic           rst,
    stream_if.snk          in,
    stream_if.src          out,
    output logic [IDW-1:0] out_id,
    output logic           busy
);
    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic [CHANNELS-1:0] full, empty, pop, ready;
    beat_t               head [CHANNELS];

    // Ready depends only on the registered full flags, never on out.ready.
    assign ready    = ~full & {CHANNELS{~rst}};
    assign in.ready = ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        stream_fifo #(
            .W     ($bits(beat_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in.valid[g] && ready[g]),
            .push_data ({in.last[g], in.data[g]}),
            .pop       (pop[g]),
            .pop_data  (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
`ifdef STREAM_MERGE_PACKET_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
`endif

    logic [IDW-1:0] grant, idx, grant_nxt;
    logic           found;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        pop     = '0;
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
`ifdef STREAM_MERGE_PACKET_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
`endif
        // First non-empty lane at or after the pointer, wrapping.
        for (int k = 0; k < CHANNELS; k++) begin
            idx = IDW'((int'(ptr_q) + k) % CHANNELS);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
`ifdef STREAM_MERGE_PACKET_LOCK_EN
        // Mid-packet only the locked lane may load, even while it is empty.
        if (lock_q) begin
            grant = lock_id_q;
            found = !empty[lock_id_q];
        end
`endif
        grant_nxt = (int'(grant) == CHANNELS - 1) ? '0 : grant + IDW'(1);

        if (!valid_q || out.ready[0]) begin
            if (found) begin
                pop[grant] = 1'b1;
                valid_d    = 1'b1;
                last_d     = head[grant].last;
                data_d     = head[grant].data;
                id_d       = grant;
`ifdef STREAM_MERGE_PACKET_LOCK_EN
                if (head[grant].last) begin
                    lock_d = 1'b0;
                    ptr_d  = grant_nxt;
                end else begin
                    lock_d    = 1'b1;
                    lock_id_d = grant;
                end
`else
                ptr_d = grant_nxt;
`endif
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef STREAM_MERGE_PACKET_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`endif

    assign out.valid = valid_q;
    assign out.last  = last_q;
    assign out.data  = data_q;
    assign out_id    = id_q;
    assign busy      = (|(~empty)) || valid_q;
endmodule

// File: tb/tb_stream_merge.sv
// tb/tb_stream_merge.sv - scoreboard bench for stream_merge
module tb_stream_merge;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int D  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] out_id;
    logic       busy;

    always #5 clk = ~clk;

    stream_if #(.LANES(CH), .WIDTH(W)) in_if ();
    stream_if #(.LANES(1),  .WIDTH(W)) out_if ();

    stream_merge #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .DEPTH    (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_if),
        .out    (out_if),
        .out_id (out_id),
        .busy   (busy)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [8:0] exp_q  [CH][$];
    logic [8:0] send_q [CH][$];
    int         obs_id [$];
    int         obs_cyc[$];
    int         acc    [CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are judged at the negedge, half a cycle before the edge that takes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_if.valid[0] && out_if.ready[0]) begin
                check("sb_pending", 32'(exp_q[out_id].size() > 0), 32'd1);
                if (exp_q[out_id].size() > 0)
                    check("out_beat", 32'({out_if.last[0], out_if.data[0]}), 32'(exp_q[out_id].pop_front()));
                obs_id.push_back(int'(out_id));
                obs_cyc.push_back(cyc);
            end
            for (int i = 0; i < CH; i++) begin
                if (in_if.valid[i] && in_if.ready[i]) begin
                    exp_q[i].push_back({in_if.last[i], in_if.data[i]});
                    acc[i]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < CH; i++) begin
            if (send_q[i].size() > 0) begin
                in_if.valid[i] = 1'b1;
                {in_if.last[i], in_if.data[i]} = send_q[i][0];
            end else begin
                in_if.valid[i] = 1'b0;
            end
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < CH; i++) n += send_q[i].size();
        return n;
    endfunction

    task automatic run(input int max_cyc, input bit to_idle);
        bit hs [CH];
        bit done = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            apply_inputs();
            @(negedge clk);
            for (int i = 0; i < CH; i++) hs[i] = in_if.valid[i] && in_if.ready[i];
            step();
            for (int i = 0; i < CH; i++) if (hs[i]) void'(send_q[i].pop_front());
            if (to_idle && pending() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        apply_inputs();
        if (to_idle) check("drain_in_budget", 32'(done), 32'd1);
    endtask

    task automatic clear_sb();
        for (int i = 0; i < CH; i++) begin
            exp_q[i].delete();
            acc[i] = 0;
        end
        obs_id.delete();
        obs_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < CH; i++) send_q[i].delete();
        apply_inputs();
        step();
        step();
        rst = 1'b0;
        clear_sb();
    endtask

    int exp_lock[5];

    initial begin
        rst          = 1'b1;
        in_if.valid  = '0;
        in_if.last   = '0;
        in_if.data   = '0;
        out_if.ready = '0;
        step();
        step();

        // reset state
        check("rst_in_ready",  32'(in_if.ready), 32'd0);
        check("rst_out_valid", 32'(out_if.valid), 32'd0);
        check("rst_out_last",  32'(out_if.last), 32'd0);
        check("rst_out_data",  32'(out_if.data), 32'd0);
        check("rst_out_id",    32'(out_id), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        rst = 1'b0;
        clear_sb();

        // single beat on lane 2
        out_if.ready = 1'b1;
        send_q[2].push_back({1'b1, 8'hA5});
        apply_inputs();
        step();
        send_q[2].delete();
        apply_inputs();
        check("single_acc", 32'(acc[2]), 32'd1);
        step();
        check("single_valid", 32'(out_if.valid), 32'd1);
        check("single_data",  32'(out_if.data), 32'hA5);
        check("single_id",    32'(out_id), 32'd2);
        check("single_busy",  32'(busy), 32'd1);
        step();
        check("single_idle_busy",  32'(busy), 32'd0);
        check("single_idle_valid", 32'(out_if.valid), 32'd0);

        // all lanes, 3 beats each: strict rotation, no gaps
        do_reset();
        out_if.ready = 1'b1;
        for (int l = 0; l < CH; l++)
            for (int b = 0; b < 3; b++)
                send_q[l].push_back({1'b1, 8'(l * 16 + b)});
        run(60, 1'b1);
        check("rr_count", 32'(obs_id.size()), 32'd12);
        for (int k = 0; k < obs_id.size() && k < 12; k++)
            check("rr_id", 32'(obs_id[k]), 32'(k % CH));
        if (obs_cyc.size() == 12)
            check("rr_no_gaps", 32'(obs_cyc[11] - obs_cyc[0]), 32'd11);

        // backpressure on lane 1
        do_reset();
        out_if.ready = 1'b0;
        for (int b = 0; b < 4; b++) send_q[1].push_back({1'b1, 8'(8'h40 + b)});
        run(4, 1'b0);
        check("bp_accepts",  32'(acc[1]), 32'(D + 1));
        check("bp_ready",    32'(in_if.ready[1]), 32'd0);
        check("bp_valid",    32'(out_if.valid), 32'd1);
        check("bp_data",     32'(out_if.data), 32'h40);
        run(3, 1'b0);
        check("bp_hold_data", 32'(out_if.data), 32'h40);
        check("bp_hold_id",   32'(out_id), 32'd1);
        check("bp_hold_acc",  32'(acc[1]), 32'(D + 1));
        out_if.ready = 1'b1;
        run(40, 1'b1);
        check("bp_out_count", 32'(obs_id.size()), 32'd4);
        check("bp_sb_left",   32'(exp_q[1].size()), 32'd0);

        // reset with two beats buffered
        do_reset();
        out_if.ready = 1'b0;
        send_q[0].push_back({1'b1, 8'h11});
        send_q[0].push_back({1'b1, 8'h12});
        run(3, 1'b0);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        send_q[0].delete();
        apply_inputs();
        #1;
        check("mid_ready_in_rst", 32'(in_if.ready), 32'd0);
        step();
        check("mid_valid", 32'(out_if.valid), 32'd0);
        check("mid_busy",  32'(busy), 32'd0);
        check("mid_ready", 32'(in_if.ready), 32'd0);
        rst = 1'b0;
        clear_sb();
        out_if.ready = 1'b1;
        send_q[3].push_back({1'b1, 8'h3C});
        run(20, 1'b1);
        check("mid_out_count", 32'(obs_id.size()), 32'd1);
        if (obs_id.size() > 0) check("mid_out_id", 32'(obs_id[0]), 32'd3);

        // packet on lane 0 competing with lane 1
        do_reset();
        out_if.ready = 1'b1;
        send_q[0].push_back({1'b0, 8'h01});
        send_q[0].push_back({1'b0, 8'h02});
        send_q[0].push_back({1'b1, 8'h03});
        send_q[1].push_back({1'b1, 8'h81});
        send_q[1].push_back({1'b1, 8'h82});
`ifdef STREAM_MERGE_PACKET_LOCK_EN
        exp_lock = '{0, 0, 0, 1, 1};
`else
        exp_lock = '{0, 1, 0, 1, 0};
`endif
        run(30, 1'b1);
        check("pkt_count", 32'(obs_id.size()), 32'd5);
        for (int k = 0; k < obs_id.size() && k < 5; k++)
            check("pkt_id", 32'(obs_id[k]), 32'(exp_lock[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
